// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 6-bit program counter.
// Selects sequential / branch / jump / call / return flow, owns the
// run/halt FSM, a runtime-written jump-target LUT and a return-address stack.
// Optional build macro: PC_SEQ_CIRCULAR_RS_EN (circular RAS, overwrite oldest on full).
module pc_sequencer #(
    parameter int unsigned PC_W      = 6,
    parameter int unsigned RS_DEPTH  = 4,
    parameter int unsigned LUT_N     = 16,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PC_W-1:0]                   pc,
    input  logic                              branch_en,
    input  logic                              branch_cond,
    input  logic                              jump_abs,
    input  logic                              call,
    input  logic                              ret,
    input  logic                              halt,
    input  logic                              stall,
    input  logic [$clog2(LUT_N)-1:0]          lut_idx,
    input  logic                              lut_wr_en,
    input  logic [$clog2(LUT_N)-1:0]          lut_wr_idx,
    input  logic [PC_W-1:0]                   lut_wr_data,
    output logic [PC_W-1:0]                   next_pc,
    output logic                              jump,
    output logic                              pc_hold,
    output logic                              running,
    output logic                              done,
    output logic [$clog2(RS_DEPTH+1)-1:0]     rs_count,
    output logic                              rs_overflow,
    output logic                              rs_underflow
);

    localparam int unsigned PTR_W = $clog2(RS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_running;
    logic                  r_done;
    logic [PC_W-1:0]       r_lut [LUT_N];
    logic [PC_W-1:0]       r_ras [RS_DEPTH];
    logic [PTR_W-1:0]      r_sp;
    logic [CNT_W-1:0]      r_rs_count;
    logic                  r_rs_overflow;
    logic                  r_rs_underflow;

    logic [PC_W-1:0]       w_lut_rd;
    logic [PTR_W-1:0]      w_top;
    logic                  w_rs_empty;
    logic                  w_rs_full;
    logic [PC_W-1:0]       w_ret_addr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_set_ovf;
    logic                  w_set_unf;
    logic                  w_clr;

    // Asynchronous LUT read and RAS top-of-stack decode.
    assign w_lut_rd   = r_lut[lut_idx];
    assign w_top      = r_sp - PTR_W'(1);
    assign w_rs_empty = (r_rs_count == CNT_W'(0));
    assign w_rs_full  = (r_rs_count == CNT_W'(RS_DEPTH));
    assign w_ret_addr = pc + PC_W'(1);

    // FSM state and registered status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state, flow decode and same-cycle PC control outputs.
    always_comb begin
        w_state_nxt = r_state;
        next_pc     = w_lut_rd;
        jump        = 1'b0;
        pc_hold     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                pc_hold = 1'b1;
                if (start) begin
                    jump        = 1'b1;
                    next_pc     = PC_W'(RESET_VEC);
                    w_clr       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stall) begin
                    pc_hold = 1'b1;
                end else if (halt) begin
                    pc_hold     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (ret) begin
                    if (w_rs_empty) begin
                        w_set_unf = 1'b1;
                    end else begin
                        jump    = 1'b1;
                        next_pc = r_ras[w_top];
                        w_pop   = 1'b1;
                    end
                end else if (call) begin
`ifdef PC_SEQ_CIRCULAR_RS_EN
                    // Full stack simply overwrites the oldest slot.
                    jump   = 1'b1;
                    w_push = 1'b1;
`else
                    if (w_rs_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        jump   = 1'b1;
                        w_push = 1'b1;
                    end
`endif
                end else if (jump_abs) begin
                    jump = 1'b1;
                end else if (branch_en && branch_cond) begin
                    jump = 1'b1;
                end
            end
            S_DONE: begin
                pc_hold = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                pc_hold     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // LUT writes and RAS push/pop; reset discards any same-edge update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(LUT_N); i++) begin
                r_lut[i] <= '0;
            end
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
            r_sp           <= '0;
            r_rs_count     <= '0;
            r_rs_overflow  <= 1'b0;
            r_rs_underflow <= 1'b0;
        end else begin
            if (lut_wr_en) begin
                r_lut[lut_wr_idx] <= lut_wr_data;
            end
            if (w_clr) begin
                r_sp           <= '0;
                r_rs_count     <= '0;
                r_rs_overflow  <= 1'b0;
                r_rs_underflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_ras[r_sp] <= w_ret_addr;
                    r_sp        <= r_sp + PTR_W'(1);
                    if (!w_rs_full) begin
                        r_rs_count <= r_rs_count + CNT_W'(1);
                    end
                end
                if (w_pop) begin
                    r_sp       <= w_top;
                    r_rs_count <= r_rs_count - CNT_W'(1);
                end
                if (w_set_ovf) begin
                    r_rs_overflow <= 1'b1;
                end
                if (w_set_unf) begin
                    r_rs_underflow <= 1'b1;
                end
            end
        end
    end

    assign running      = r_running;
    assign done         = r_done;
    assign rs_count     = r_rs_count;
    assign rs_overflow  = r_rs_overflow;
    assign rs_underflow = r_rs_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vectors with literal expectations,
// plus a queue-based reference model compared every cycle.
module tb_pc_sequencer;

    localparam int unsigned PC_W     = 6;
    localparam int unsigned RS_DEPTH = 4;
    localparam int unsigned LUT_N    = 16;
`ifdef PC_SEQ_CIRCULAR_RS_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] pc;
    logic            branch_en, branch_cond, jump_abs, call, ret, halt, stall;
    logic [3:0]      lut_idx;
    logic            lut_wr_en;
    logic [3:0]      lut_wr_idx;
    logic [PC_W-1:0] lut_wr_data;
    logic [PC_W-1:0] next_pc;
    logic            jump, pc_hold, running, done;
    logic [2:0]      rs_count;
    logic            rs_overflow, rs_underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc),
        .branch_en(branch_en), .branch_cond(branch_cond), .jump_abs(jump_abs),
        .call(call), .ret(ret), .halt(halt), .stall(stall),
        .lut_idx(lut_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
        .lut_wr_data(lut_wr_data), .next_pc(next_pc), .jump(jump),
        .pc_hold(pc_hold), .running(running), .done(done), .rs_count(rs_count),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: 0=IDLE 1=RUN 2=DONE, stack as a queue (back = top).
    int              m_state = 0;
    logic [PC_W-1:0] m_lut [LUT_N];
    logic [PC_W-1:0] m_stk [$];
    bit              m_ovf = 1'b0;
    bit              m_unf = 1'b0;

    initial begin
        for (int i = 0; i < int'(LUT_N); i++) m_lut[i] = '0;
    end

    // Per-cycle comparison of DUT against the model, then model advance.
    always @(negedge clk) begin : cmp
        logic            ej, eh;
        logic [PC_W-1:0] en;
        if (chk_en) begin
            chk("m_running", 32'(running), 32'(m_state == 1));
            chk("m_done", 32'(done), 32'(m_state == 2));
            chk("m_rs_count", 32'(rs_count), 32'(m_stk.size()));
            chk("m_rs_ovf", 32'(rs_overflow), 32'(m_ovf));
            chk("m_rs_unf", 32'(rs_underflow), 32'(m_unf));
            ej = 1'b0; eh = 1'b0; en = m_lut[lut_idx];
            if (m_state == 0) begin
                eh = 1'b1;
                if (start) begin ej = 1'b1; en = '0; end
            end else if (m_state == 2) begin
                eh = 1'b1;
            end else if (stall || halt) begin
                eh = 1'b1;
            end else if (ret) begin
                if (m_stk.size() > 0) begin ej = 1'b1; en = m_stk[$]; end
            end else if (call) begin
                if (m_stk.size() < int'(RS_DEPTH) || CIRC) ej = 1'b1;
            end else if (jump_abs || (branch_en && branch_cond)) begin
                ej = 1'b1;
            end
            chk("m_jump", 32'(jump), 32'(ej));
            chk("m_pc_hold", 32'(pc_hold), 32'(eh));
            chk("m_next_pc", 32'(next_pc), 32'(en));
            if (!reset) begin
                m_state = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
                for (int i = 0; i < int'(LUT_N); i++) m_lut[i] = '0;
            end else begin
                if (m_state == 0) begin
                    if (start) begin
                        m_state = 1; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
                    end
                end else if (m_state == 2) begin
                    if (!start) m_state = 0;
                end else if (stall) begin
                end else if (halt) begin
                    m_state = 2;
                end else if (ret) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else m_unf = 1'b1;
                end else if (call) begin
                    if (m_stk.size() < int'(RS_DEPTH)) begin
                        m_stk.push_back(pc + PC_W'(1));
                    end else if (CIRC) begin
                        void'(m_stk.pop_front());
                        m_stk.push_back(pc + PC_W'(1));
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_ctl();
        start = 0; branch_en = 0; branch_cond = 0; jump_abs = 0;
        call = 0; ret = 0; halt = 0; stall = 0; lut_wr_en = 0;
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [PC_W-1:0] d);
        lut_wr_en = 1; lut_wr_idx = idx; lut_wr_data = d;
        tick();
        lut_wr_en = 0;
    endtask

    logic [PC_W-1:0] exp_ret [4];

    initial begin
        reset = 0; pc = '0; lut_idx = '0; lut_wr_idx = '0; lut_wr_data = '0;
        clear_ctl();
        #1;
        chk_en = 1'b1;
        tick(); tick();
        settle();
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rs_count", 32'(rs_count), 32'd0);
        chk("rst_idle_hold", 32'(pc_hold), 32'd1);
        chk("rst_idle_jump", 32'(jump), 32'd0);

        reset = 1;
        tick();
        lut_write(4'd3, 6'd20);
        lut_write(4'd5, 6'd40);
        lut_write(4'd7, 6'd33);

        // Start: jump to reset vector in the start cycle.
        start = 1; settle();
        chk("start_jump", 32'(jump), 32'd1);
        chk("start_next_pc", 32'(next_pc), 32'd0);
        tick(); start = 0;
        chk("start_running", 32'(running), 32'd1);
        pc = 6'd1; settle();
        chk("noop_jump", 32'(jump), 32'd0);
        chk("noop_hold", 32'(pc_hold), 32'd0);
        tick();

        // Single call / return.
        pc = 6'd5; call = 1; lut_idx = 4'd3; settle();
        chk("call_jump", 32'(jump), 32'd1);
        chk("call_next_pc", 32'(next_pc), 32'd20);
        tick(); call = 0;
        chk("call_rs_count", 32'(rs_count), 32'd1);
        pc = 6'd25; ret = 1; settle();
        chk("ret_jump", 32'(jump), 32'd1);
        chk("ret_next_pc", 32'(next_pc), 32'd6);
        tick(); ret = 0;
        chk("ret_rs_count", 32'(rs_count), 32'd0);

        // Five nested calls.
        for (int i = 0; i < 5; i++) begin
            pc = PC_W'(10 + i); call = 1; settle();
            if (i < 4) chk("nest_jump", 32'(jump), 32'd1);
            tick();
        end
        call = 0;
        chk("nest_rs_count", 32'(rs_count), 32'd4);
`ifdef PC_SEQ_CIRCULAR_RS_EN
        chk("nest_ovf", 32'(rs_overflow), 32'd0);
        exp_ret[0] = 6'd15; exp_ret[1] = 6'd14; exp_ret[2] = 6'd13; exp_ret[3] = 6'd12;
`else
        chk("nest_ovf", 32'(rs_overflow), 32'd1);
        exp_ret[0] = 6'd14; exp_ret[1] = 6'd13; exp_ret[2] = 6'd12; exp_ret[3] = 6'd11;
`endif
        for (int i = 0; i < 4; i++) begin
            pc = 6'd30; ret = 1; settle();
            chk("unwind_next_pc", 32'(next_pc), 32'(exp_ret[i]));
            tick();
        end

        // Return with empty stack, sticky underflow.
        settle();
        chk("empty_jump", 32'(jump), 32'd0);
        chk("empty_hold", 32'(pc_hold), 32'd0);
        tick(); ret = 0;
        chk("unf_set", 32'(rs_underflow), 32'd1);
        tick();
        chk("unf_sticky", 32'(rs_underflow), 32'd1);

        // Call at pc=63 pushes wrapped 0.
        pc = 6'd63; call = 1; lut_idx = 4'd3; tick(); call = 0;
        ret = 1; settle();
        chk("wrap_next_pc", 32'(next_pc), 32'd0);
        tick(); ret = 0;

        // Branches and absolute jump.
        branch_en = 1; branch_cond = 0; lut_idx = 4'd5; settle();
        chk("br_nt_jump", 32'(jump), 32'd0);
        branch_cond = 1; settle();
        chk("br_t_next_pc", 32'(next_pc), 32'd40);
        tick(); branch_en = 0; branch_cond = 0;
        jump_abs = 1; lut_idx = 4'd7; settle();
        chk("jabs_next_pc", 32'(next_pc), 32'd33);
        tick();

        // stall + halt + jump_abs, then halt + jump_abs.
        stall = 1; halt = 1; settle();
        chk("stall_hold", 32'(pc_hold), 32'd1);
        chk("stall_jump", 32'(jump), 32'd0);
        tick(); stall = 0;
        chk("stall_running", 32'(running), 32'd1);
        settle();
        chk("halt_jump", 32'(jump), 32'd0);
        tick(); halt = 0; jump_abs = 0;
        chk("halt_done", 32'(done), 32'd1);

        // DONE holds while start, then IDLE, then restart clears flags.
        start = 1; tick();
        chk("done_stays", 32'(done), 32'd1);
        start = 0; tick();
        chk("back_idle", 32'(done | running), 32'd0);
        start = 1; tick(); start = 0;
        chk("restart_unf", 32'(rs_underflow), 32'd0);
        chk("restart_running", 32'(running), 32'd1);

        // Reset mid-call with a LUT write in flight.
        pc = 6'd20; call = 1; lut_idx = 4'd3; reset = 0;
        lut_wr_en = 1; lut_wr_idx = 4'd3; lut_wr_data = 6'd50;
        tick();
        reset = 1; call = 0; lut_wr_en = 0; settle();
        chk("mid_rst_running", 32'(running), 32'd0);
        chk("mid_rst_count", 32'(rs_count), 32'd0);
        chk("mid_rst_lut", 32'(next_pc), 32'd0);

        // Same-cycle LUT write/read returns old value.
        lut_wr_en = 1; lut_wr_idx = 4'd3; lut_wr_data = 6'd9; settle();
        chk("wr_rd_old", 32'(next_pc), 32'd0);
        tick(); lut_wr_en = 0; settle();
        chk("wr_rd_new", 32'(next_pc), 32'd9);
        tick(); tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
